pam_4_encode: RTL and testbench

- Transmit-side PAM-4 mapper for the Tx simulation path; it is the counterpart of the existing PAM-4 decoder.
- Accepts DATA_WIDTH-bit binary words over a valid/ready handshake and serialises each word into DATA_WIDTH/2 two-bit symbols, MSB pair first.
- Drives one signed voltage-level code per symbol toward the channel model, honouring downstream backpressure.
- Level codes are bit-exact with the decoder's expectations, so encoder→decoder loopback is lossless.

---
 rtl/pam4_pkg.sv | 28 ++
 rtl/pam_4_encode.sv | 101 ++++++++++
 tb/tb_pam_4_encode.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/pam4_pkg.sv
// Shared PAM-4 definitions used by the Tx encoder and the Rx decoder.
// Holds the symbol type, the default level codes and the level mapping function.
package pam4_pkg;

   localparam int unsigned PAM4_SYM_W = 2;

   typedef logic [PAM4_SYM_W-1:0] pam4_sym_t;

   // Level codes at SIGNAL_RESOLUTION=8, SYMBOL_SEPERATION=56
   localparam logic [7:0] PAM4_LEVEL_00 = 8'hAC;  // -84
   localparam logic [7:0] PAM4_LEVEL_01 = 8'hE4;  // -28
   localparam logic [7:0] PAM4_LEVEL_10 = 8'h1C;  // +28
   localparam logic [7:0] PAM4_LEVEL_11 = 8'h54;  // +84

   // level(s) = (2*s - 3) * separation/2, kept to the low 'resolution' bits
   function automatic logic [31:0] pam4_level(input pam4_sym_t   sym,
                                              input int unsigned resolution,
                                              input int unsigned separation);
      int          step;
      int          code;
      logic [31:0] mask;
      step = int'(separation / 2);
      code = (2 * int'({30'b0, sym}) - 3) * step;
      mask = (resolution >= 32) ? '1 : ((32'd1 << resolution) - 32'd1);
      return 32'(code) & mask;
   endfunction

endpackage

// File: rtl/pam_4_encode.sv
// PAM-4 transmit mapper: serialises DATA_WIDTH-bit words into DATA_WIDTH/2
// two-bit symbols (MSB pair first) and emits one signed level code per symbol.
// Ports:
//   clk, rst                  clock and synchronous active-high reset
//   data_in / _valid / _ready word input handshake (ready is combinational)
//   voltage_level_out / _valid / _ready / _last  level stream toward the channel
module pam_4_encode
   import pam4_pkg::*;
#(
   parameter int unsigned DATA_WIDTH        = 8,
   parameter int unsigned SIGNAL_RESOLUTION = 8,
   parameter int unsigned SYMBOL_SEPERATION = 56
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [DATA_WIDTH-1:0]        data_in,
   input  logic                         data_in_valid,
   output logic                         data_in_ready,
   output logic [SIGNAL_RESOLUTION-1:0] voltage_level_out,
   output logic                         voltage_level_out_valid,
   input  logic                         voltage_level_out_ready,
   output logic                         voltage_level_out_last
);

   localparam int unsigned SYMS  = DATA_WIDTH / 2;
   localparam int unsigned CNT_W = ($clog2(SYMS + 1) > 3) ? $clog2(SYMS + 1) : 3;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_SEND = 1'b1
   } state_e;

   state_e                       state_c;
   logic [CNT_W-1:0]             cnt_q,   cnt_d;
   logic [DATA_WIDTH-1:0]        shift_q, shift_d, shift_nxt;
   logic [SIGNAL_RESOLUTION-1:0] level_q, level_d;
   logic                         valid_q, valid_d;
   logic                         last_q,  last_d;
   logic                         load;

   // State is implied by the remaining-symbol count
   assign state_c = (cnt_q == '0) ? ST_IDLE : ST_SEND;

   // Ready also on the final symbol's handshake so words stream without a bubble
   assign data_in_ready = !rst && ((state_c == ST_IDLE) ||
                                   ((cnt_q == CNT_W'(1)) && voltage_level_out_ready));
   assign load          = data_in_valid && data_in_ready;

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q   <= '0;
         shift_q <= '0;
         level_q <= '0;
         valid_q <= 1'b0;
         last_q  <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         shift_q <= shift_d;
         level_q <= level_d;
         valid_q <= valid_d;
         last_q  <= last_d;
      end
   end

   // Next-state: load a word (also as a reload on the last symbol) or advance on handshake
   always_comb begin
      cnt_d     = cnt_q;
      shift_d   = shift_q;
      level_d   = level_q;
      valid_d   = valid_q;
      last_d    = last_q;
      shift_nxt = shift_q << 2;

      if (load) begin
         shift_d = data_in;
         cnt_d   = CNT_W'(SYMS);
         level_d = SIGNAL_RESOLUTION'(pam4_level(data_in[DATA_WIDTH-1 -: 2],
                                                 SIGNAL_RESOLUTION, SYMBOL_SEPERATION));
         valid_d = 1'b1;
         last_d  = (SYMS == 1);
      end else if ((state_c == ST_SEND) && voltage_level_out_ready) begin
         if (cnt_q > CNT_W'(1)) begin
            shift_d = shift_nxt;
            cnt_d   = cnt_q - CNT_W'(1);
            level_d = SIGNAL_RESOLUTION'(pam4_level(shift_nxt[DATA_WIDTH-1 -: 2],
                                                    SIGNAL_RESOLUTION, SYMBOL_SEPERATION));
            last_d  = (cnt_q == CNT_W'(2));
         end else begin
            cnt_d   = '0;
            valid_d = 1'b0;
            last_d  = 1'b0;
         end
      end
   end

   assign voltage_level_out       = level_q;
   assign voltage_level_out_valid = valid_q;
   assign voltage_level_out_last  = last_q;

endmodule

// File: tb/tb_pam_4_encode.sv
// Self-checking bench for pam_4_encode: a queue-based symbol model checked every
// cycle, directed scenarios with literal level codes, a randomized stream that is
// decoded back to bytes, and a DATA_WIDTH=2 instance.
module tb_pam_4_encode;

   typedef struct packed {
      logic [7:0] lvl;
      logic       last;
   } sym_t;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] din;
   logic       dv, dr, or_, vv, vlast;
   logic [7:0] vl;
   logic [1:0] din2;
   logic       dv2, dr2, or2, vv2, vlast2;
   logic [7:0] vl2;

   int   errors = 0;
   int   checks = 0;
   int   words  = 0;
   int   syms_seen = 0;
   sym_t exp_q[$];
   sym_t obs_q[$];
   sym_t exp2_q[$];
   sym_t obs2_q[$];
   logic [7:0] in_q[$];

   always #5 clk = ~clk;

   pam_4_encode #(.DATA_WIDTH(8), .SIGNAL_RESOLUTION(8), .SYMBOL_SEPERATION(56)) u_dut (
      .clk(clk), .rst(rst),
      .data_in(din), .data_in_valid(dv), .data_in_ready(dr),
      .voltage_level_out(vl), .voltage_level_out_valid(vv),
      .voltage_level_out_ready(or_), .voltage_level_out_last(vlast)
   );

   pam_4_encode #(.DATA_WIDTH(2), .SIGNAL_RESOLUTION(8), .SYMBOL_SEPERATION(56)) u_dut2 (
      .clk(clk), .rst(rst),
      .data_in(din2), .data_in_valid(dv2), .data_in_ready(dr2),
      .voltage_level_out(vl2), .voltage_level_out_valid(vv2),
      .voltage_level_out_ready(or2), .voltage_level_out_last(vlast2)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
      end
   endtask

   // Level from the mapping rule, 8-bit two's complement
   function automatic logic [7:0] lvl(input int s);
      int v;
      v = (2 * s - 3) * 28;
      return v[7:0];
   endfunction

   function automatic sym_t mk(input logic [7:0] l, input logic last);
      sym_t s;
      s.lvl  = l;
      s.last = last;
      return s;
   endfunction

   task automatic chk_obs(input string name, input int idx, input logic [7:0] l, input logic last);
      if (idx < obs_q.size()) begin
         chk({name, "_lvl"}, 32'(obs_q[idx].lvl), 32'(l));
         chk({name, "_last"}, 32'(obs_q[idx].last), 32'(last));
      end else begin
         chk({name, "_missing"}, 32'(obs_q.size()), 32'(idx + 1));
      end
   endtask

   // Compare process: model expectations against DUT outputs every cycle
   always @(negedge clk) begin : compare
      logic rdy, rdy2;
      #1;
      if (rst) begin
         chk("in_ready_rst", 32'(dr), 32'd0);
         chk("in_ready2_rst", 32'(dr2), 32'd0);
         exp_q.delete();
         exp2_q.delete();
      end else begin
         rdy = (exp_q.size() == 0) || (exp_q.size() == 1 && or_);
         chk("in_ready", 32'(dr), 32'(rdy));
         chk("out_valid", 32'(vv), 32'(exp_q.size() != 0));
         if (exp_q.size() != 0) begin
            chk("level", 32'(vl), 32'(exp_q[0].lvl));
            chk("last", 32'(vlast), 32'(exp_q[0].last));
            if (or_) begin
               obs_q.push_back(mk(vl, vlast));
               void'(exp_q.pop_front());
               syms_seen++;
            end
         end
         if (dv && rdy) begin
            in_q.push_back(din);
            words++;
            for (int k = 0; k < 4; k++)
               exp_q.push_back(mk(lvl(int'(din[7-2*k -: 2])), k == 3));
         end

         rdy2 = (exp2_q.size() == 0) || (exp2_q.size() == 1 && or2);
         chk("in_ready2", 32'(dr2), 32'(rdy2));
         chk("out_valid2", 32'(vv2), 32'(exp2_q.size() != 0));
         if (exp2_q.size() != 0) begin
            chk("level2", 32'(vl2), 32'(exp2_q[0].lvl));
            chk("last2", 32'(vlast2), 32'(exp2_q[0].last));
            if (or2) begin
               obs2_q.push_back(mk(vl2, vlast2));
               void'(exp2_q.pop_front());
            end
         end
         if (dv2 && rdy2) exp2_q.push_back(mk(lvl(int'(din2)), 1'b1));
      end
   end

   task automatic idle_cycles(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         dv  = 1'b0;
         or_ = 1'b1;
      end
   endtask

   initial begin : stim
      int bp[7];
      int w0, v, s;
      logic [7:0] b;
      rst = 1'b1; din = '0; dv = 1'b0; or_ = 1'b1;
      din2 = '0; dv2 = 1'b0; or2 = 1'b1;
      bp = '{1, 0, 0, 1, 1, 0, 1};
      repeat (3) @(negedge clk);
      rst = 1'b0;
      #2;
      chk("rst_level", 32'(vl), 32'h00);
      chk("rst_valid", 32'(vv), 32'd0);
      chk("rst_last", 32'(vlast), 32'd0);

      // Single word 1B
      obs_q.delete();
      @(negedge clk); dv = 1'b1; din = 8'h1B; or_ = 1'b1;
      idle_cycles(6);
      chk("w1b_count", 32'(obs_q.size()), 32'd4);
      chk_obs("w1b_0", 0, 8'hAC, 1'b0);
      chk_obs("w1b_1", 1, 8'hE4, 1'b0);
      chk_obs("w1b_2", 2, 8'h1C, 1'b0);
      chk_obs("w1b_3", 3, 8'h54, 1'b1);

      // Back-to-back FF then 00
      obs_q.delete();
      @(negedge clk); dv = 1'b1; din = 8'hFF;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk); dv = 1'b1; din = 8'h00;
      end
      idle_cycles(6);
      chk("b2b_count", 32'(obs_q.size()), 32'd8);
      for (int i = 0; i < 8; i++)
         chk_obs("b2b", i, (i < 4) ? 8'h54 : 8'hAC, (i == 3) || (i == 7));

      // Backpressure on 6C
      obs_q.delete();
      @(negedge clk); dv = 1'b1; din = 8'h6C; or_ = 1'b1;
      for (int i = 0; i < 7; i++) begin
         @(negedge clk); dv = 1'b0; or_ = (bp[i] != 0);
      end
      idle_cycles(4);
      chk("bp_count", 32'(obs_q.size()), 32'd4);
      chk_obs("bp_0", 0, 8'hE4, 1'b0);
      chk_obs("bp_1", 1, 8'h1C, 1'b0);
      chk_obs("bp_2", 2, 8'h54, 1'b0);
      chk_obs("bp_3", 3, 8'hAC, 1'b1);

      // Reset after two symbols of E4, then 1B starts from its MSB pair
      obs_q.delete();
      @(negedge clk); dv = 1'b1; din = 8'hE4; or_ = 1'b1;
      @(negedge clk); dv = 1'b0;
      @(negedge clk);
      @(negedge clk); rst = 1'b1;
      @(negedge clk); rst = 1'b0;
      #2;
      chk("midrst_valid", 32'(vv), 32'd0);
      chk("midrst_last", 32'(vlast), 32'd0);
      chk("midrst_ready", 32'(dr), 32'd1);
      @(negedge clk); dv = 1'b1; din = 8'h1B;
      idle_cycles(6);
      chk("midrst_count", 32'(obs_q.size()), 32'd6);
      chk_obs("midrst_0", 0, 8'h54, 1'b0);
      chk_obs("midrst_1", 1, 8'h1C, 1'b0);
      chk_obs("midrst_2", 2, 8'hAC, 1'b0);
      chk_obs("midrst_5", 5, 8'h54, 1'b1);

      // DATA_WIDTH=2 corner: 0,1,2,3 streamed with ready held high
      obs2_q.delete();
      for (int i = 0; i < 4; i++) begin
         @(negedge clk); dv2 = 1'b1; din2 = 2'(i); or2 = 1'b1;
      end
      @(negedge clk); dv2 = 1'b0;
      repeat (3) @(negedge clk);
      chk("dw2_count", 32'(obs2_q.size()), 32'd4);
      for (int i = 0; i < 4; i++) begin
         if (i < obs2_q.size()) begin
            chk("dw2_lvl", 32'(obs2_q[i].lvl), 32'(lvl(i)));
            chk("dw2_last", 32'(obs2_q[i].last), 32'd1);
         end
      end
      chk("lvl_pin_00", 32'(lvl(0)), 32'hAC);
      chk("lvl_pin_11", 32'(lvl(3)), 32'h54);

      // Randomized stream, decoded back to bytes
      obs_q.delete();
      in_q.delete();
      w0 = words;
      syms_seen = 0;
      for (int c = 0; c < 20000 && (words - w0) < 1000; c++) begin
         @(negedge clk);
         dv  = ($urandom_range(0, 3) != 0);
         din = 8'($urandom);
         or_ = ($urandom_range(0, 3) != 0);
      end
      chk("rand_words_reached", 32'((words - w0) >= 1000), 32'd1);
      idle_cycles(10);
      chk("rand_sym_count", 32'(syms_seen), 32'(4 * (words - w0)));
      for (int i = 0; i < in_q.size(); i++) begin
         b = '0;
         for (int k = 0; k < 4; k++) begin
            if (4 * i + k < obs_q.size()) begin
               v = int'($signed(obs_q[4*i+k].lvl));
               s = (v / 28 + 3) / 2;
               b = {b[5:0], 2'(s)};
            end
         end
         chk("rand_byte", 32'(b), 32'(in_q[i]));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
